// File: rtl/pic_irr_priority_resolver_pkg.sv
// Shared types and constants for the PIC request/priority front end.
package pic_pkg;
  localparam int unsigned IR_WIDTH    = 8;
  localparam int unsigned LEVEL_WIDTH = 3;
  localparam logic [LEVEL_WIDTH-1:0] SPURIOUS_LEVEL = 3'd7;

  typedef enum logic {
    IDLE,
    WAIT2
  } pic_state_e;

  function automatic logic [IR_WIDTH-1:0] level_onehot(input logic [LEVEL_WIDTH-1:0] lvl);
    logic [IR_WIDTH-1:0] r;
    r      = '0;
    r[lvl] = 1'b1;
    return r;
  endfunction
endpackage

// File: rtl/pic_irr_priority_resolver_if.sv
// Request/acknowledge bundle between the PIC control logic and the IRR resolver.
// Optional auto-EOI signals exist only when PIC_AUTO_EOI_EN is defined.
interface pic_irr_priority_resolver_if;
  import pic_pkg::*;

  logic [IR_WIDTH-1:0]    ir_in;
  logic                   ltim;
  logic [IR_WIDTH-1:0]    interrupt_mask;
  logic [IR_WIDTH-1:0]    in_service_register;
  logic                   inta_pulse;
  logic                   rotate_on_eoi;
  logic                   eoi_pulse;
  logic [LEVEL_WIDTH-1:0] eoi_level;
  logic                   int_out;
  logic [IR_WIDTH-1:0]    interrupt_request;
  logic [IR_WIDTH-1:0]    ack_set;
  logic [LEVEL_WIDTH-1:0] ack_vector;
  logic                   vector_valid;
  logic [LEVEL_WIDTH-1:0] lowest_prio;
`ifdef PIC_AUTO_EOI_EN
  logic                   auto_eoi_mode;
  logic [IR_WIDTH-1:0]    auto_eoi_clear;
`endif

  modport slave (
    input  ir_in, ltim, interrupt_mask, in_service_register, inta_pulse,
           rotate_on_eoi, eoi_pulse, eoi_level,
`ifdef PIC_AUTO_EOI_EN
    input  auto_eoi_mode,
    output auto_eoi_clear,
`endif
    output int_out, interrupt_request, ack_set, ack_vector, vector_valid, lowest_prio
  );

  modport master (
    output ir_in, ltim, interrupt_mask, in_service_register, inta_pulse,
           rotate_on_eoi, eoi_pulse, eoi_level,
`ifdef PIC_AUTO_EOI_EN
    output auto_eoi_mode,
    input  auto_eoi_clear,
`endif
    input  int_out, interrupt_request, ack_set, ack_vector, vector_valid, lowest_prio
  );
endinterface

// File: rtl/pic_irr_priority_resolver_rotator.sv
// Combinational rotating-priority resolve: first candidate after lowest_prio wins;
// also reports the rank of the highest in-service level for the nesting compare.
module pic_priority_rotator
  import pic_pkg::*;
(
  input  logic [IR_WIDTH-1:0]    candidates,
  input  logic [IR_WIDTH-1:0]    in_service,
  input  logic [LEVEL_WIDTH-1:0] lowest_prio,
  output logic                   winner_valid,
  output logic [LEVEL_WIDTH-1:0] winner_level,
  output logic [LEVEL_WIDTH-1:0] winner_rank,
  output logic                   isr_valid,
  output logic [LEVEL_WIDTH-1:0] isr_rank
);
  logic [LEVEL_WIDTH-1:0] base;
  logic [LEVEL_WIDTH-1:0] lvl;

  always_comb begin
    base         = lowest_prio + 3'd1;
    lvl          = '0;
    winner_valid = 1'b0;
    winner_level = '0;
    winner_rank  = '0;
    isr_valid    = 1'b0;
    isr_rank     = '0;
    // Rank k is the k-th level visited from base; modulo-8 wrap comes from the 3-bit add.
    for (int unsigned k = 0; k < IR_WIDTH; k++) begin
      lvl = base + LEVEL_WIDTH'(k);
      if (!winner_valid && candidates[lvl]) begin
        winner_valid = 1'b1;
        winner_level = lvl;
        winner_rank  = LEVEL_WIDTH'(k);
      end
      if (!isr_valid && in_service[lvl]) begin
        isr_valid = 1'b1;
        isr_rank  = LEVEL_WIDTH'(k);
      end
    end
  end
endmodule

// File: rtl/pic_irr_priority_resolver.sv
// PIC IRR capture, fully-nested priority resolve and two-pulse INTA sequencer.
// Optional auto-EOI at the second INTA is enabled with PIC_AUTO_EOI_EN.
module pic_irr_priority_resolver
  import pic_pkg::*;
#(
  parameter int unsigned NUM_IR            = 8,
  parameter logic [2:0]  RESET_LOWEST_PRIO = 3'd7
) (
  input logic                        clk,
  input logic                        reset,
  pic_irr_priority_resolver_if.slave bus
);
  pic_state_e state, state_d;

  logic [NUM_IR-1:0]      irr, irr_d, prev_ir, edge_base;
  logic [IR_WIDTH-1:0]    ack_set_r, ack_set_d;
  logic [LEVEL_WIDTH-1:0] ack_vector_r, ack_vector_d;
  logic [LEVEL_WIDTH-1:0] lowest_r, lowest_d;
  logic                   vector_valid_r, vector_valid_d;
  logic                   int_out_r, int_out_d;

  logic                   winner_valid, isr_valid;
  logic [LEVEL_WIDTH-1:0] winner_level, winner_rank, isr_rank;

`ifdef PIC_AUTO_EOI_EN
  logic                   ack_spur_r, ack_spur_d;
  logic [IR_WIDTH-1:0]    auto_clear_r, auto_clear_d;
`endif

  pic_priority_rotator u_rotator (
    .candidates   (irr & ~bus.interrupt_mask),
    .in_service   (bus.in_service_register),
    .lowest_prio  (lowest_r),
    .winner_valid (winner_valid),
    .winner_level (winner_level),
    .winner_rank  (winner_rank),
    .isr_valid    (isr_valid),
    .isr_rank     (isr_rank)
  );

  always_comb begin
    state_d        = state;
    ack_set_d      = '0;
    ack_vector_d   = ack_vector_r;
    vector_valid_d = 1'b0;
    lowest_d       = lowest_r;
`ifdef PIC_AUTO_EOI_EN
    ack_spur_d     = ack_spur_r;
    auto_clear_d   = '0;
`endif
    case (state)
      IDLE: begin
        if (bus.inta_pulse) begin
          state_d = WAIT2;
          if (winner_valid) begin
            ack_set_d    = level_onehot(winner_level);
            ack_vector_d = winner_level;
          end else begin
            ack_vector_d = SPURIOUS_LEVEL;
          end
`ifdef PIC_AUTO_EOI_EN
          ack_spur_d = !winner_valid;
`endif
        end
      end
      WAIT2: begin
        if (bus.inta_pulse) begin
          state_d        = IDLE;
          vector_valid_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (bus.eoi_pulse && bus.rotate_on_eoi)
      lowest_d = bus.eoi_level;
`ifdef PIC_AUTO_EOI_EN
    if (vector_valid_d && bus.auto_eoi_mode && !ack_spur_r) begin
      auto_clear_d = level_onehot(ack_vector_r);
      if (bus.rotate_on_eoi)
        lowest_d = ack_vector_r;
    end
`endif

    int_out_d = (state_d == IDLE) && winner_valid && (!isr_valid || (winner_rank < isr_rank));
  end

  // Acknowledge clear is applied last so it beats a same-cycle edge on the acked bit.
  always_comb begin
    edge_base = (irr & bus.ir_in) | (bus.ir_in & ~prev_ir);
    irr_d     = (bus.ltim ? bus.ir_in : edge_base) & ~ack_set_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      irr            <= '0;
      prev_ir        <= '0;
      ack_set_r      <= '0;
      ack_vector_r   <= '0;
      vector_valid_r <= 1'b0;
      int_out_r      <= 1'b0;
      lowest_r       <= RESET_LOWEST_PRIO;
`ifdef PIC_AUTO_EOI_EN
      ack_spur_r     <= 1'b0;
      auto_clear_r   <= '0;
`endif
    end else begin
      irr            <= irr_d;
      prev_ir        <= bus.ir_in;
      ack_set_r      <= ack_set_d;
      ack_vector_r   <= ack_vector_d;
      vector_valid_r <= vector_valid_d;
      int_out_r      <= int_out_d;
      lowest_r       <= lowest_d;
`ifdef PIC_AUTO_EOI_EN
      ack_spur_r     <= ack_spur_d;
      auto_clear_r   <= auto_clear_d;
`endif
    end
  end

  assign bus.int_out           = int_out_r;
  assign bus.interrupt_request = irr;
  assign bus.ack_set           = ack_set_r;
  assign bus.ack_vector        = ack_vector_r;
  assign bus.vector_valid      = vector_valid_r;
  assign bus.lowest_prio       = lowest_r;
`ifdef PIC_AUTO_EOI_EN
  assign bus.auto_eoi_clear    = auto_clear_r;
`endif
endmodule

// File: tb/tb_pic_irr_priority_resolver.sv
// Self-checking bench for pic_irr_priority_resolver: table-driven level-mode nesting
// checks plus hand sequences; vectors are scoreboarded on vector_valid.
module tb_pic_irr_priority_resolver;
  import pic_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pic_irr_priority_resolver_if bus ();

  pic_irr_priority_resolver #(
    .NUM_IR            (8),
    .RESET_LOWEST_PRIO (3'd7)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int compared   = 0;
  int mismatched = 0;
  logic [2:0] vec_q[$];

  typedef struct {
    logic [7:0] ir;
    logic [7:0] mask;
    logic [7:0] isr;
    logic       exp_int;
  } vec_t;

  vec_t tbl[10];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_inta();
    bus.inta_pulse = 1'b1;
    tick();
    bus.inta_pulse = 1'b0;
  endtask

  // Vector scoreboard: every vector_valid must match the oldest pending expectation.
  always @(negedge clk) begin
    if (reset === 1'b0 && bus.vector_valid === 1'b1) begin
      if (vec_q.size() == 0) begin
        check("vector_unexpected", 8'(bus.vector_valid), 8'h00);
      end else begin
        check("vector_level", 8'(bus.ack_vector), 8'(vec_q.pop_front()));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    tbl[0] = '{8'h08, 8'h00, 8'h02, 1'b0};
    tbl[1] = '{8'h01, 8'h00, 8'h02, 1'b1};
    tbl[2] = '{8'h02, 8'h00, 8'h02, 1'b0};
    tbl[3] = '{8'h40, 8'h00, 8'h00, 1'b1};
    tbl[4] = '{8'h40, 8'h40, 8'h00, 1'b0};
    tbl[5] = '{8'h40, 8'h00, 8'h00, 1'b1};
    tbl[6] = '{8'h00, 8'h00, 8'h00, 1'b0};
    tbl[7] = '{8'h81, 8'h01, 8'h80, 1'b0};
    tbl[8] = '{8'h81, 8'h00, 8'h80, 1'b1};
    tbl[9] = '{8'hff, 8'hfe, 8'h01, 1'b0};

    reset                   = 1'b1;
    bus.ir_in               = '0;
    bus.ltim                = 1'b0;
    bus.interrupt_mask      = '0;
    bus.in_service_register = '0;
    bus.inta_pulse          = 1'b0;
    bus.rotate_on_eoi       = 1'b0;
    bus.eoi_pulse           = 1'b0;
    bus.eoi_level           = '0;
`ifdef PIC_AUTO_EOI_EN
    bus.auto_eoi_mode       = 1'b0;
`endif
    tick();
    tick();
    reset = 1'b0;
    check("rst_irr",    bus.interrupt_request, 8'h00);
    check("rst_int",    8'(bus.int_out), 8'h00);
    check("rst_ackset", bus.ack_set, 8'h00);
    check("rst_ackvec", 8'(bus.ack_vector), 8'h00);
    check("rst_vvalid", 8'(bus.vector_valid), 8'h00);
    check("rst_lowest", 8'(bus.lowest_prio), 8'h07);

    // Edge capture of IR3, ack with a coincident new edge on IR5.
    bus.ir_in = 8'h08;
    tick();
    check("edge_irr", bus.interrupt_request, 8'h08);
    tick();
    check("edge_int", 8'(bus.int_out), 8'h01);
    bus.ir_in = 8'h28;
    pulse_inta();
    check("ack1_set",    bus.ack_set, 8'h08);
    check("ack1_irr",    bus.interrupt_request, 8'h20);
    check("ack1_int",    8'(bus.int_out), 8'h00);
    check("ack1_vec",    8'(bus.ack_vector), 8'h03);
    tick();
    check("ack1_pulse",  bus.ack_set, 8'h00);
    vec_q.push_back(3'd3);
    pulse_inta();
    check("ack1_vvalid", 8'(bus.vector_valid), 8'h01);
    tick();
    check("ack1_vdone",  8'(bus.vector_valid), 8'h00);
    bus.ir_in = 8'h00;
    tick();
    tick();
    check("drain1", 8'(vec_q.size()), 8'h00);

    // Rotation: IR2 wins at lowest=7, IR5 wins after rotating to lowest=2.
    bus.ir_in = 8'h24;
    tick();
    tick();
    pulse_inta();
    check("rot_ack_a", bus.ack_set, 8'h04);
    check("rot_int_w2", 8'(bus.int_out), 8'h00);
    vec_q.push_back(3'd2);
    pulse_inta();
    bus.eoi_pulse     = 1'b1;
    bus.rotate_on_eoi = 1'b1;
    bus.eoi_level     = 3'd2;
    tick();
    bus.eoi_pulse     = 1'b0;
    bus.rotate_on_eoi = 1'b0;
    check("rot_lowest", 8'(bus.lowest_prio), 8'h02);
    bus.ir_in = 8'h00;
    tick();
    bus.ir_in = 8'h24;
    tick();
    tick();
    pulse_inta();
    check("rot_ack_b", bus.ack_set, 8'h20);
    vec_q.push_back(3'd5);
    pulse_inta();
    bus.ir_in     = 8'h00;
    bus.eoi_pulse = 1'b1;
    bus.eoi_level = 3'd3;
    tick();
    check("eoi_norot", 8'(bus.lowest_prio), 8'h02);
    bus.rotate_on_eoi = 1'b1;
    bus.eoi_level     = 3'd7;
    tick();
    bus.eoi_pulse     = 1'b0;
    bus.rotate_on_eoi = 1'b0;
    check("rot_back", 8'(bus.lowest_prio), 8'h07);
    tick();
    tick();

    // Level mode: nesting against ISR and masking, from the table.
    bus.ltim = 1'b1;
    tick();
    for (int i = 0; i < 10; i++) begin
      bus.ir_in               = tbl[i].ir;
      bus.interrupt_mask      = tbl[i].mask;
      bus.in_service_register = tbl[i].isr;
      tick();
      check($sformatf("tbl%0d_irr", i), bus.interrupt_request, tbl[i].ir);
      tick();
      check($sformatf("tbl%0d_int", i), 8'(bus.int_out), 8'(tbl[i].exp_int));
    end

    // Spurious: nothing pending, then only a masked request pending.
    bus.ir_in               = '0;
    bus.interrupt_mask      = '0;
    bus.in_service_register = '0;
    tick();
    tick();
    pulse_inta();
    check("spur_set", bus.ack_set, 8'h00);
    check("spur_vec", 8'(bus.ack_vector), 8'h07);
    vec_q.push_back(3'd7);
    pulse_inta();
    bus.ir_in          = 8'h10;
    bus.interrupt_mask = 8'h10;
    tick();
    tick();
    pulse_inta();
    check("spurm_set", bus.ack_set, 8'h00);
    check("spurm_irr", bus.interrupt_request, 8'h10);
    vec_q.push_back(3'd7);
    pulse_inta();
    bus.ir_in          = '0;
    bus.interrupt_mask = '0;
    bus.ltim           = 1'b0;
    tick();
    tick();

    // Reset while waiting for the second INTA.
    bus.ir_in = 8'h02;
    tick();
    tick();
    pulse_inta();
    check("rw_ack", bus.ack_set, 8'h02);
    bus.eoi_pulse     = 1'b1;
    bus.rotate_on_eoi = 1'b1;
    bus.eoi_level     = 3'd4;
    tick();
    bus.eoi_pulse     = 1'b0;
    bus.rotate_on_eoi = 1'b0;
    check("rw_lowest4", 8'(bus.lowest_prio), 8'h04);
    reset     = 1'b1;
    bus.ir_in = 8'h00;
    tick();
    reset = 1'b0;
    check("rw_irr",    bus.interrupt_request, 8'h00);
    check("rw_int",    8'(bus.int_out), 8'h00);
    check("rw_ackset", bus.ack_set, 8'h00);
    check("rw_ackvec", 8'(bus.ack_vector), 8'h00);
    check("rw_vvalid", 8'(bus.vector_valid), 8'h00);
    check("rw_lowest", 8'(bus.lowest_prio), 8'h07);
    pulse_inta();
    check("rw_first_vv", 8'(bus.vector_valid), 8'h00);
    check("rw_first_vec", 8'(bus.ack_vector), 8'h07);
    vec_q.push_back(3'd7);
    pulse_inta();
    tick();
    tick();
    check("drain_end", 8'(vec_q.size()), 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
